down_counter_timer: RTL and testbench



---
 rtl/down_counter_timer_pkg.sv | 11 +
 rtl/down_counter_timer_if.sv | 26 ++
 rtl/down_counter_timer_sub_n.sv | 11 +
 rtl/down_counter_timer.sv | 78 +++++++
 tb/tb_down_counter_timer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/down_counter_timer_pkg.sv
// Shared types and constants for the loadable down-counter/timer.
package down_counter_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/down_counter_timer_if.sv
// Load handshake, control and status bundle of the down-counter/timer.
interface down_counter_timer_if
    import down_counter_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] I;
    logic             LOAD_VALID;
    logic             LOAD_READY;
    logic             CE;
    logic             RELOAD;
    logic             ABORT;
    logic [WIDTH-1:0] O;
    logic             BUSY;
    logic             TC;

    modport master (
        output I, LOAD_VALID, CE, RELOAD, ABORT,
        input  LOAD_READY, O, BUSY, TC
    );

    modport slave (
        input  I, LOAD_VALID, CE, RELOAD, ABORT,
        output LOAD_READY, O, BUSY, TC
    );
endinterface

// File: rtl/down_counter_timer_sub_n.sv
// Combinational WIDTH-bit decrementer, counterpart of the up-counter's adder.
module down_counter_timer_sub_n
    import down_counter_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = a_i - WIDTH'(1);
endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter with valid/ready load, count enable, abort,
// optional auto-reload and a registered one-cycle terminal-count pulse.
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RESET,
    down_counter_timer_if.slave  bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] dec;

    down_counter_timer_sub_n #(.WIDTH(WIDTH)) u_dec (
        .a_i (o_q),
        .y_o (dec)
    );

    always_comb begin
        state_d  = state_q;
        o_d      = o_q;
        period_d = period_q;
        tc_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.LOAD_VALID) begin
                    o_d      = bus.I;
                    period_d = bus.I;
                    // A zero period fires immediately and never enters RUN.
                    if (bus.I != '0) state_d = RUN;
                    else             tc_d    = 1'b1;
                end
            end
            RUN: begin
                if (bus.ABORT) begin
                    o_d     = '0;
                    state_d = IDLE;
                end else if (bus.CE) begin
                    if (o_q == WIDTH'(1)) begin
                        tc_d = 1'b1;
                        if (bus.RELOAD) begin
                            o_d = period_q;
                        end else begin
                            o_d     = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        o_d = dec;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            o_q      <= '0;
            period_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            o_q      <= o_d;
            period_q <= period_d;
            tc_q     <= tc_d;
        end
    end

    assign bus.O          = o_q;
    assign bus.TC         = tc_q;
    assign bus.BUSY       = (state_q == RUN);
    assign bus.LOAD_READY = (state_q == IDLE);
endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer with a per-cycle reference model.
module tb_down_counter_timer;
    import down_counter_timer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;

    down_counter_timer_if #(.WIDTH(4)) bus ();

    down_counter_timer #(.WIDTH(4)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: remaining enabled ticks until the terminal count.
    int m_o = 0, m_per = 0, m_tc = 0, m_busy = 0;
    bit started = 1'b0;

    always @(posedge clk) begin
        started <= 1'b1;
        m_tc    <= 0;
        if (rst) begin
            m_o <= 0; m_per <= 0; m_busy <= 0;
        end else if (m_busy == 0) begin
            if (bus.LOAD_VALID) begin
                m_per <= int'(bus.I);
                m_o   <= int'(bus.I);
                if (bus.I == 4'd0) m_tc   <= 1;
                else               m_busy <= 1;
            end
        end else if (bus.ABORT) begin
            m_o <= 0; m_busy <= 0;
        end else if (bus.CE) begin
            if (m_o - 1 == 0) begin
                m_tc <= 1;
                if (bus.RELOAD) m_o <= m_per;
                else begin m_o <= 0; m_busy <= 0; end
            end else begin
                m_o <= m_o - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_O",     int'(bus.O),          m_o);
            check("model_TC",    int'(bus.TC),         m_tc);
            check("model_BUSY",  int'(bus.BUSY),       m_busy);
            check("model_READY", int'(bus.LOAD_READY), 1 - m_busy);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int o, input int tc, input int busy);
        check({name, "_O"},    int'(bus.O),    o);
        check({name, "_TC"},   int'(bus.TC),   tc);
        check({name, "_BUSY"}, int'(bus.BUSY), busy);
    endtask

    initial begin
        int exp_o [7];
        int exp_tc[7];
        int ce_pat[7];
        int ce_o  [7];
        int k;
        exp_o  = '{2, 1, 2, 1, 2, 1, 2};
        exp_tc = '{0, 0, 1, 0, 1, 0, 1};
        ce_pat = '{1, 0, 0, 1, 1, 0, 1};
        ce_o   = '{3, 3, 3, 2, 1, 1, 0};

        bus.I = '0; bus.LOAD_VALID = 0; bus.CE = 0; bus.RELOAD = 0; bus.ABORT = 0;
        step(); step();
        rst = 1'b0;
        lit("reset", 0, 0, 0);
        check("reset_READY", int'(bus.LOAD_READY), 1);

        // Single shot of 3.
        bus.I = 4'd3; bus.LOAD_VALID = 1; bus.CE = 1;
        step(); bus.LOAD_VALID = 0;
        lit("t1_load", 3, 0, 1);
        step(); lit("t1_c1", 2, 0, 1);
        step(); lit("t1_c2", 1, 0, 1);
        step(); lit("t1_c3", 0, 1, 0);
        check("t1_READY", int'(bus.LOAD_READY), 1);
        step(); lit("t1_c4", 0, 0, 0);

        // Auto-reload with period 2.
        bus.I = 4'd2; bus.LOAD_VALID = 1; bus.RELOAD = 1;
        step(); bus.LOAD_VALID = 0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            lit($sformatf("t2_%0d", i), exp_o[i], exp_tc[i], 1);
        end
        bus.RELOAD = 0;
        step(); step();
        lit("t2_stop", 0, 1, 0);

        // Gated counting.
        bus.I = 4'd4; bus.LOAD_VALID = 1;
        step(); bus.LOAD_VALID = 0;
        lit("t3_load", 4, 0, 1);
        for (int i = 0; i < 7; i++) begin
            bus.CE = ce_pat[i][0];
            step();
            lit($sformatf("t3_%0d", i), ce_o[i], (i == 6) ? 1 : 0, (i == 6) ? 0 : 1);
        end
        bus.CE = 1;

        // Load request during RUN is ignored; abort mid-count.
        bus.I = 4'd5; bus.LOAD_VALID = 1;
        step();
        bus.I = 4'd9;
        step(); bus.LOAD_VALID = 0;
        lit("t4_ignored", 4, 0, 1);
        step(); lit("t4_at3", 3, 0, 1);
        bus.ABORT = 1;
        step(); bus.ABORT = 0;
        lit("t4_abort", 0, 0, 0);

        // ABORT in IDLE does not block a load; it then aborts the run.
        bus.ABORT = 1; bus.I = 4'd3; bus.LOAD_VALID = 1;
        step(); bus.LOAD_VALID = 0;
        lit("t4_idle_abort", 3, 0, 1);
        step(); bus.ABORT = 0;
        lit("t4_abort2", 0, 0, 0);

        // Zero-length timer.
        bus.I = 4'd0; bus.LOAD_VALID = 1;
        step(); bus.LOAD_VALID = 0;
        lit("t5_zero", 0, 1, 0);
        step(); lit("t5_zero_after", 0, 0, 0);

        // Maximum period.
        bus.I = 4'd15; bus.LOAD_VALID = 1;
        step(); bus.LOAD_VALID = 0;
        lit("t5_max_load", 15, 0, 1);
        k = 0;
        do begin
            step();
            k++;
        end while (!bus.TC && k < 40);
        check("t5_max_cycles", k, 15);

        // Reset mid-count, then short load and a back-to-back load on TC.
        bus.I = 4'd8; bus.LOAD_VALID = 1;
        step(); bus.LOAD_VALID = 0;
        step(); step();
        lit("t6_at6", 6, 0, 1);
        rst = 1'b1;
        step(); rst = 1'b0;
        lit("t6_reset", 0, 0, 0);
        bus.I = 4'd1; bus.LOAD_VALID = 1;
        step(); bus.LOAD_VALID = 0;
        lit("t6_load1", 1, 0, 1);
        bus.I = 4'd2; bus.LOAD_VALID = 1;
        step();
        lit("t6_tc", 0, 1, 0);
        step(); bus.LOAD_VALID = 0;
        lit("t6_b2b", 2, 0, 1);
        bus.ABORT = 1;
        step(); bus.ABORT = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
